// File: rtl/ospi_ram_arbiter.sv
// ospi_ram_arbiter
// Shares one single-port byte RAM between an OSPI slave engine (port A) and a
// host bus (port B). Port A always wins and is served combinationally in the
// same cycle. The host is only granted while the OSPI chip select is idle and
// a configurable guard interval has elapsed since the last OSPI transaction.
// Host reads return data one cycle after the grant with a one-cycle strobe.

module ospi_ram_arbiter #(
    parameter int AW        = 8,  // RAM address width, depth 2^AW bytes
    parameter int GUARD_CYC = 2   // idle cycles after ncs rises, 1..15
) (
    input  logic          clk,
    input  logic          reset_n,

    // OSPI engine side
    input  logic          ncs,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    output logic [7:0]    a_rdata,

    // Host side
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_wdata,
    output logic          b_gnt,
    output logic [7:0]    b_rdata,
    output logic          b_rvalid,

    // RAM port
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,

    // Status
    output logic          busy,
    output logic [7:0]    txn_cnt,
    output logic          err_oob,
    input  logic          err_clr
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OSPI  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    // Guard counter counts down from GUARD_CYC-1 to 0, so GUARD lasts
    // exactly GUARD_CYC cycles when ncs stays high.
    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYC - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0] state_q,    state_d;
    logic [3:0] guard_q,    guard_d;
    logic [7:0] txn_cnt_q,  txn_cnt_d;
    logic       err_oob_q,  err_oob_d;
    logic       b_rvalid_q, b_rvalid_d;
    logic [7:0] b_rdata_q,  b_rdata_d;

    logic       txn_done;

    // Next-state and guard countdown for the IDLE / OSPI / GUARD sequencer
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d  = state_q;
        guard_d  = guard_q;
        txn_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ncs) begin
                    state_d = ST_OSPI;
                end
            end
            ST_OSPI: begin
                if (ncs) begin
                    state_d  = ST_GUARD;
                    guard_d  = GUARD_LOAD;
                    txn_done = 1'b1;
                end
            end
            ST_GUARD: begin
                if (!ncs) begin
                    // A new transaction can start at any point of the guard.
                    state_d = ST_OSPI;
                end else if (guard_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            default: begin
                // Unused encoding: fall back to a safe idle state.
                state_d = ST_IDLE;
                guard_d = 4'd0;
            end
        endcase
    end

    // Host grant and RAM port multiplexer; port A has absolute priority
    always_comb begin
        // The grant is masked during reset so a stale state cannot leak a
        // host access before the first reset edge has been taken.
        b_gnt = b_req & ~a_req & ncs & (state_q == ST_IDLE) & reset_n;

        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 8'h00;
        if (a_req) begin
            ram_en    = 1'b1;
            ram_we    = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end else if (b_gnt) begin
            ram_en    = 1'b1;
            ram_we    = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end
    end

    // Transaction counter, sticky error flag and host read pipeline
    always_comb begin
        txn_cnt_d  = txn_done ? txn_cnt_q + 8'd1 : txn_cnt_q;
        // Set has priority over clear so a simultaneous error is not lost.
        err_oob_d  = (a_req & ncs) | (err_oob_q & ~err_clr);
        // Only host reads produce a data strobe; host writes complete silently.
        b_rvalid_d = b_gnt & ~b_we;
        // The RAM output is forwarded while the strobe is high and the last
        // returned byte is held afterwards.
        b_rdata_d  = b_rvalid_q ? ram_rdata : b_rdata_q;
    end

    // State and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others, independent of order.
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            guard_q    <= 4'd0;
            txn_cnt_q  <= 8'd0;
            err_oob_q  <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            txn_cnt_q  <= txn_cnt_d;
            err_oob_q  <= err_oob_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // Output assignments
    assign a_rdata  = ram_rdata;
    assign b_rdata  = b_rdata_d;
    assign b_rvalid = b_rvalid_q;
    assign busy     = (state_q == ST_OSPI) || (state_q == ST_GUARD);
    assign txn_cnt  = txn_cnt_q;
    assign err_oob  = err_oob_q;

endmodule

// File: tb/tb_ospi_ram_arbiter.sv
// Directed testbench for ospi_ram_arbiter with a behavioural 256x8 RAM.

module tb_ospi_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ncs;
    logic       a_req, a_we;
    logic [7:0] a_addr, a_wdata, a_rdata;
    logic       b_req, b_we;
    logic [7:0] b_addr, b_wdata;
    logic       b_gnt;
    logic [7:0] b_rdata;
    logic       b_rvalid;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata;
    logic       busy;
    logic [7:0] txn_cnt;
    logic       err_oob;
    logic       err_clr;

    int total = 0;
    int bad   = 0;
    int cyc;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    ospi_ram_arbiter #(.AW(8), .GUARD_CYC(2)) dut (
        .clk(clk), .reset_n(reset_n), .ncs(ncs),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .busy(busy), .txn_cnt(txn_cnt), .err_oob(err_oob), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ram_rdata = 8'h00;
        reset_n = 1'b0; ncs = 1'b1; err_clr = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h10; b_wdata = 8'h00;

        // ---------------- reset state ----------------
        #1;
        check("rst_gnt_pre", b_gnt, 1'b0);
        check("rst_en_pre", ram_en, 1'b0);
        step(); step();
        check("rst_busy", busy, 1'b0);
        check("rst_txn", txn_cnt, 8'd0);
        check("rst_err", err_oob, 1'b0);
        check("rst_rvalid", b_rvalid, 1'b0);
        check("rst_rdata", b_rdata, 8'h00);
        check("rst_gnt", b_gnt, 1'b0);
        reset_n = 1'b1;

        // ---------------- host write then read ----------------
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h10; b_wdata = 8'h5A;
        #1;
        check("hw_gnt", b_gnt, 1'b1);
        check("hw_ram_we", ram_we, 1'b1);
        check("hw_ram_addr", ram_addr, 8'h10);
        check("hw_ram_wdata", ram_wdata, 8'h5A);
        step();
        b_we = 1'b1; b_addr = 8'h11; b_wdata = 8'h33;
        #1;
        check("hw2_rvalid", b_rvalid, 1'b0);
        step();
        b_we = 1'b0; b_addr = 8'h10;
        #1;
        check("hr_gnt", b_gnt, 1'b1);
        check("hr_no_rvalid_after_wr", b_rvalid, 1'b0);
        step();
        b_addr = 8'h11;
        #1;
        check("b2b_gnt", b_gnt, 1'b1);
        check("hr_rvalid", b_rvalid, 1'b1);
        check("hr_rdata", b_rdata, 8'h5A);
        step();
        b_req = 1'b0;
        #1;
        check("b2b_rvalid", b_rvalid, 1'b1);
        check("b2b_rdata", b_rdata, 8'h33);
        step();
        check("rvalid_drop", b_rvalid, 1'b0);
        check("rdata_hold", b_rdata, 8'h33);

        // ---------------- OSPI burst blocks host, guard timing ----------------
        ncs = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 8'h10;
        #1;
        check("ncs_fall_busy", busy, 1'b0);
        check("ncs_fall_gnt", b_gnt, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20 + 8'(i); a_wdata = 8'hA0 + 8'(i);
            #1;
            check("ospi_gnt", b_gnt, 1'b0);
            check("ospi_ram_addr", ram_addr, 8'h20 + 8'(i));
            check("ospi_busy", busy, 1'b1);
            step();
        end
        a_req = 1'b0; ncs = 1'b1;
        #1;
        check("ncs_rise_gnt", b_gnt, 1'b0);
        cyc = 0;
        while (cyc < 10) begin
            step();
            cyc++;
            if (cyc == 1) check("guard_busy", busy, 1'b1);
            if (b_gnt) break;
        end
        check("guard_gnt_delay", cyc, 3);
        check("txn_one", txn_cnt, 8'd1);
        step();
        b_req = 1'b0;
        #1;
        check("post_guard_rvalid", b_rvalid, 1'b1);
        check("post_guard_rdata", b_rdata, 8'h5A);

        // ---------------- read granted in last IDLE cycle ----------------
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h21;
        #1;
        check("last_idle_gnt", b_gnt, 1'b1);
        step();
        ncs = 1'b0; b_req = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 8'h23;
        #1;
        check("last_idle_rvalid", b_rvalid, 1'b1);
        check("last_idle_rdata", b_rdata, 8'hA1);
        check("a_served_en", ram_en, 1'b1);
        check("a_served_addr", ram_addr, 8'h23);
        step();
        a_req = 1'b0;
        #1;
        check("a_rdata", a_rdata, 8'hA3);
        check("a_rd_busy", busy, 1'b1);
        ncs = 1'b1;
        step(); step(); step();
        check("txn_two", txn_cnt, 8'd2);
        check("back_idle", busy, 1'b0);

        // ---------------- out-of-bounds access flag ----------------
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h22;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h10;
        #1;
        check("oob_gnt", b_gnt, 1'b0);
        check("oob_ram_addr", ram_addr, 8'h22);
        step();
        check("oob_set", err_oob, 1'b1);
        check("oob_a_rdata", a_rdata, 8'hA2);
        b_req = 1'b0; err_clr = 1'b1;
        step();
        check("oob_set_wins", err_oob, 1'b1);
        a_req = 1'b0;
        step();
        check("oob_clr", err_oob, 1'b0);
        err_clr = 1'b0;

        // ---------------- txn_cnt wrap ----------------
        for (int i = 0; i < 254; i++) begin
            ncs = 1'b0; step();
            ncs = 1'b1; step();
            if (i == 252) check("txn_255", txn_cnt, 8'd255);
        end
        check("txn_wrap", txn_cnt, 8'd0);

        // ---------------- reset during GUARD with host read pending ----------------
        ncs = 1'b0; step();
        ncs = 1'b1; step();
        check("guard_txn", txn_cnt, 8'd1);
        check("guard_busy2", busy, 1'b1);
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h10; reset_n = 1'b0;
        #1;
        check("rst_guard_gnt", b_gnt, 1'b0);
        step();
        check("rst_guard_idle", busy, 1'b0);
        check("rst_guard_rvalid", b_rvalid, 1'b0);
        check("rst_guard_txn", txn_cnt, 8'd0);
        reset_n = 1'b1;
        #1;
        check("after_rst_gnt", b_gnt, 1'b1);
        step();
        b_req = 1'b0;
        #1;
        check("after_rst_rvalid", b_rvalid, 1'b1);
        check("after_rst_rdata", b_rdata, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
